// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and types for the 1-D convolution core
package conv_pkg;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_ADDR_W = 5;

  // Worst-case sum of 2^ADDR_W products of two DATA_W samples
  function automatic int acc_width(input int data_w, input int addr_w);
    return 2 * data_w + addr_w;
  endfunction

  localparam int CONV_ACC_W = acc_width(CONV_DATA_W, CONV_ADDR_W);

  typedef enum logic {
    Y_SRC_DIFF = 1'b0,
    Y_SRC_K    = 1'b1
  } y_src_e;

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - multiply-accumulator with clear-over-enable priority
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int ACC_W  = CONV_ACC_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d, acc_q;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv_datapath.sv
// rtl/conv_datapath.sv - index counters, memory addresses, MAC and loop flags
module conv_datapath
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int ADDR_W = CONV_ADDR_W,
  parameter int ACC_W  = CONV_ACC_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              busy_i,
  input  logic [ADDR_W-1:0] sizeX_i,
  input  logic [ADDR_W-1:0] sizeY_i,
  input  logic              i_clr_i,
  input  logic              j_clr_i,
  input  logic              i_en_i,
  input  logic              j_en_i,
  input  logic              k_en_i,
  input  logic              selI_i,
  input  logic              selJ_i,
  input  logic              selK_i,
  input  logic              selY_i,
  input  logic              memX_addr_en_i,
  input  logic              memY_addr_en_i,
  input  logic              memZ_addr_en_i,
  input  logic              memX_addr_clr_i,
  input  logic              memY_addr_clr_i,
  input  logic              memZ_addr_clr_i,
  input  logic              dataZ_en_i,
  input  logic              dataZ_clr_i,
  input  logic              writeZ_i,
  input  logic [DATA_W-1:0] dataX_i,
  input  logic [DATA_W-1:0] dataY_i,
  output logic [ADDR_W-1:0] memX_addr_o,
  output logic [ADDR_W-1:0] memY_addr_o,
  output logic [ADDR_W:0]   memZ_addr_o,
  output logic [ACC_W-1:0]  memZ_data_o,
  output logic              memZ_we_o,
  output logic              comp_i_sizeY_o,
  output logic              comp_j_valid_o,
  output logic              comp_i_sizeX_o,
  output logic              comp_j_sizeX_o
);

  localparam int CW = ADDR_W + 1;
  localparam int FW = ADDR_W + 2;

  logic [ADDR_W-1:0] sx_d, sx_q, sy_d, sy_q;
  logic [CW-1:0]     i_d, i_q, j_d, j_q, k_d, k_q;
  logic [ADDR_W-1:0] memx_addr_d, memx_addr_q, memy_addr_d, memy_addr_q;
  logic [CW-1:0]     memz_addr_d, memz_addr_q;
  logic [ADDR_W-1:0] y_diff;
  logic [FW-1:0]     i_w, j_w, sx_w, sy_w, lim_x;

  // Y index in phase 1 is n-j; modular truncation matches the address width
  assign y_diff = i_q[ADDR_W-1:0] - j_q[ADDR_W-1:0];

  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    memx_addr_d = memx_addr_q;
    memy_addr_d = memy_addr_q;
    memz_addr_d = memz_addr_q;

    if (start_i && !busy_i) begin
      sx_d = (sizeX_i == '0) ? ADDR_W'(1) : sizeX_i;
      sy_d = (sizeY_i == '0) ? ADDR_W'(1) : sizeY_i;
    end

    if (i_clr_i)     i_d = '0;
    else if (i_en_i) i_d = selI_i ? CW'(sy_q) : i_q + CW'(1);

    if (j_clr_i)     j_d = '0;
    else if (j_en_i) j_d = selJ_i ? i_q - CW'(sy_q) + CW'(1) : j_q + CW'(1);

    if (k_en_i)      k_d = selK_i ? k_q - CW'(1) : CW'(sy_q) - CW'(1);

    if (memX_addr_clr_i)     memx_addr_d = '0;
    else if (memX_addr_en_i) memx_addr_d = j_q[ADDR_W-1:0];

    if (memY_addr_clr_i)     memy_addr_d = '0;
    else if (memY_addr_en_i) memy_addr_d = (selY_i == Y_SRC_K) ? k_q[ADDR_W-1:0] : y_diff;

    if (memZ_addr_clr_i)     memz_addr_d = '0;
    else if (memZ_addr_en_i) memz_addr_d = memz_addr_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sx_q        <= '0;
      sy_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      memx_addr_q <= '0;
      memy_addr_q <= '0;
      memz_addr_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      memx_addr_q <= memx_addr_d;
      memy_addr_q <= memy_addr_d;
      memz_addr_q <= memz_addr_d;
    end
  end

  conv_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rstn (rstn),
    .clr_i(dataZ_clr_i),
    .en_i (dataZ_en_i),
    .a_i  (dataX_i),
    .b_i  (dataY_i),
    .acc_o(memZ_data_o)
  );

  // Widened by two bits so sX+sY-1 never wraps
  assign i_w   = FW'(i_q);
  assign j_w   = FW'(j_q);
  assign sx_w  = FW'(sx_q);
  assign sy_w  = FW'(sy_q);
  assign lim_x = sx_w + sy_w - FW'(1);

  assign comp_i_sizeY_o = i_w < sy_w;
  assign comp_j_valid_o = (j_w <= i_w) && (j_w < sx_w);
  assign comp_i_sizeX_o = i_w < lim_x;
  assign comp_j_sizeX_o = j_w < sx_w;

  assign memX_addr_o = memx_addr_q;
  assign memY_addr_o = memy_addr_q;
  assign memZ_addr_o = memz_addr_q;
  // Gated by rstn so a write strobe cannot escape while reset is asserted
  assign memZ_we_o   = writeZ_i & rstn;

endmodule

// File: tb/tb_conv_datapath.sv
// tb/tb_conv_datapath.sv - self-checking bench for conv_datapath
module tb_conv_datapath;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int ACCW = 2 * DW + AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn, start_i, busy_i;
  logic [AW-1:0]   sizeX_i, sizeY_i;
  logic            i_clr_i, j_clr_i, i_en_i, j_en_i, k_en_i;
  logic            selI_i, selJ_i, selK_i, selY_i;
  logic            memX_addr_en_i, memY_addr_en_i, memZ_addr_en_i;
  logic            memX_addr_clr_i, memY_addr_clr_i, memZ_addr_clr_i;
  logic            dataZ_en_i, dataZ_clr_i, writeZ_i;
  logic [DW-1:0]   dataX_i, dataY_i;
  logic [AW-1:0]   memX_addr_o, memY_addr_o;
  logic [AW:0]     memZ_addr_o;
  logic [ACCW-1:0] memZ_data_o;
  logic            memZ_we_o;
  logic            comp_i_sizeY_o, comp_j_valid_o, comp_i_sizeX_o, comp_j_sizeX_o;

  logic [DW-1:0] memX [32];
  logic [DW-1:0] memY [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int addr;
    int data;
  } zexp_t;
  zexp_t sb[$];

  conv_datapath dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .busy_i         (busy_i),
    .sizeX_i        (sizeX_i),
    .sizeY_i        (sizeY_i),
    .i_clr_i        (i_clr_i),
    .j_clr_i        (j_clr_i),
    .i_en_i         (i_en_i),
    .j_en_i         (j_en_i),
    .k_en_i         (k_en_i),
    .selI_i         (selI_i),
    .selJ_i         (selJ_i),
    .selK_i         (selK_i),
    .selY_i         (selY_i),
    .memX_addr_en_i (memX_addr_en_i),
    .memY_addr_en_i (memY_addr_en_i),
    .memZ_addr_en_i (memZ_addr_en_i),
    .memX_addr_clr_i(memX_addr_clr_i),
    .memY_addr_clr_i(memY_addr_clr_i),
    .memZ_addr_clr_i(memZ_addr_clr_i),
    .dataZ_en_i     (dataZ_en_i),
    .dataZ_clr_i    (dataZ_clr_i),
    .writeZ_i       (writeZ_i),
    .dataX_i        (dataX_i),
    .dataY_i        (dataY_i),
    .memX_addr_o    (memX_addr_o),
    .memY_addr_o    (memY_addr_o),
    .memZ_addr_o    (memZ_addr_o),
    .memZ_data_o    (memZ_data_o),
    .memZ_we_o      (memZ_we_o),
    .comp_i_sizeY_o (comp_i_sizeY_o),
    .comp_j_valid_o (comp_j_valid_o),
    .comp_i_sizeX_o (comp_i_sizeX_o),
    .comp_j_sizeX_o (comp_j_sizeX_o)
  );

  task automatic clear_ctrl();
    start_i = 0; i_clr_i = 0; j_clr_i = 0; i_en_i = 0; j_en_i = 0; k_en_i = 0;
    selI_i = 0; selJ_i = 0; selK_i = 0; selY_i = 0;
    memX_addr_en_i = 0; memY_addr_en_i = 0; memZ_addr_en_i = 0;
    memX_addr_clr_i = 0; memY_addr_clr_i = 0; memZ_addr_clr_i = 0;
    dataZ_en_i = 0; dataZ_clr_i = 0; writeZ_i = 0;
  endtask

  // One clock; the memories return data for the address held before the edge
  task automatic tick();
    logic [AW-1:0] ax, ay;
    ax = memX_addr_o;
    ay = memY_addr_o;
    @(posedge clk);
    #1;
    dataX_i = memX[ax];
    dataY_i = memY[ay];
    clear_ctrl();
  endtask

  task automatic apply_reset();
    rstn = 0;
    clear_ctrl();
    busy_i = 0; sizeX_i = '0; sizeY_i = '0; dataX_i = '0; dataY_i = '0;
    for (int a = 0; a < 32; a++) begin
      memX[a] = '0;
      memY[a] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic run_conv(input int sx, input int sy);
    int jlo, jhi, acc;
    zexp_t e;
    busy_i = 0; start_i = 1; sizeX_i = AW'(sx); sizeY_i = AW'(sy);
    i_clr_i = 1; memZ_addr_clr_i = 1;
    tick();
    busy_i = 1;
    for (int n = 0; n <= sx + sy - 2; n++) begin
      jlo = (n - sy + 1 > 0) ? n - sy + 1 : 0;
      jhi = (n < sx - 1) ? n : sx - 1;
      acc = 0;
      for (int j = jlo; j <= jhi; j++) acc += memX[j] * memY[n - j];
      sb.push_back('{n, acc % (1 << ACCW)});
      checks++;
      if (comp_i_sizeY_o !== (n < sy)) begin
        errors++;
        $display("FAIL i_sizeY n=%0d: got %0b expected %0b", n, comp_i_sizeY_o, n < sy);
      end
      checks++;
      if (comp_i_sizeX_o !== 1'b1) begin
        errors++;
        $display("FAIL i_sizeX_run n=%0d: got %0b expected 1", n, comp_i_sizeX_o);
      end
      dataZ_clr_i = 1;
      if (n < sy) j_clr_i = 1;
      else begin
        j_en_i = 1; selJ_i = 1; k_en_i = 1; selK_i = 0;
      end
      tick();
      for (int j = jlo; j <= jhi; j++) begin
        checks++;
        if (comp_j_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL j_valid_in n=%0d j=%0d: got %0b expected 1", n, j, comp_j_valid_o);
        end
        memX_addr_en_i = 1; memY_addr_en_i = 1; selY_i = (n >= sy); j_en_i = 1;
        if (n >= sy) begin
          k_en_i = 1; selK_i = 1;
        end
        tick();
        tick();
        dataZ_en_i = 1;
        tick();
      end
      checks++;
      if (comp_j_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL j_valid_end n=%0d: got %0b expected 0", n, comp_j_valid_o);
      end
      writeZ_i = 1; memZ_addr_en_i = 1; i_en_i = 1;
      #1;
      e = sb.pop_front();
      checks++;
      if (memZ_we_o !== 1'b1 || memZ_data_o !== ACCW'(e.data) || memZ_addr_o !== (AW+1)'(e.addr)) begin
        errors++;
        $display("FAIL z_write: got we=%0b addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
                 memZ_we_o, memZ_addr_o, memZ_data_o, e.addr, e.data);
      end
      tick();
    end
    checks++;
    if (comp_i_sizeX_o !== 1'b0) begin
      errors++;
      $display("FAIL i_sizeX_done: got %0b expected 0", comp_i_sizeX_o);
    end
    busy_i = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (memX_addr_o !== '0 || memY_addr_o !== '0 || memZ_addr_o !== '0 || memZ_data_o !== '0 || memZ_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d z=%0d acc=%0d we=%0b expected all 0",
               memX_addr_o, memY_addr_o, memZ_addr_o, memZ_data_o, memZ_we_o);
    end
    checks++;
    if (comp_i_sizeY_o !== 1'b0 || comp_j_valid_o !== 1'b0 || comp_j_sizeX_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got iY=%0b jv=%0b jX=%0b expected 0 0 0",
               comp_i_sizeY_o, comp_j_valid_o, comp_j_sizeX_o);
    end
  endtask

  task automatic test_conv_3x2();
    apply_reset();
    memX[0] = 1; memX[1] = 2; memX[2] = 3;
    memY[0] = 4; memY[1] = 5;
    run_conv(3, 2);
  endtask

  task automatic test_conv_1x1();
    apply_reset();
    memX[0] = 7; memY[0] = 9;
    run_conv(1, 1);
  endtask

  task automatic test_size_load();
    apply_reset();
    busy_i = 0; start_i = 1; sizeX_i = '0; sizeY_i = 3; i_clr_i = 1; j_clr_i = 1;
    tick();
    checks++;
    if (comp_j_sizeX_o !== 1'b1 || comp_i_sizeY_o !== 1'b1) begin
      errors++;
      $display("FAIL sizes_loaded: got jX=%0b iY=%0b expected 1 1", comp_j_sizeX_o, comp_i_sizeY_o);
    end
    j_en_i = 1;
    tick();
    checks++;
    if (comp_j_sizeX_o !== 1'b0) begin
      errors++;
      $display("FAIL sx_zero_as_one: got %0b expected 0", comp_j_sizeX_o);
    end
    busy_i = 1; start_i = 1; sizeX_i = 5;
    tick();
    checks++;
    if (comp_j_sizeX_o !== 1'b0) begin
      errors++;
      $display("FAIL sx_busy_hold: got %0b expected 0", comp_j_sizeX_o);
    end
    j_clr_i = 1; j_en_i = 1;
    tick();
    checks++;
    if (comp_j_sizeX_o !== 1'b1 || comp_j_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL j_clr_priority: got jX=%0b jv=%0b expected 1 1", comp_j_sizeX_o, comp_j_valid_o);
    end
    busy_i = 0;
  endtask

  task automatic test_acc_priority();
    apply_reset();
    memX[0] = 3; memY[0] = 4;
    tick();
    tick();
    dataZ_en_i = 1;
    tick();
    checks++;
    if (memZ_data_o !== ACCW'(12)) begin
      errors++;
      $display("FAIL acc_first: got %0d expected 12", memZ_data_o);
    end
    dataZ_en_i = 1;
    tick();
    checks++;
    if (memZ_data_o !== ACCW'(24)) begin
      errors++;
      $display("FAIL acc_accum: got %0d expected 24", memZ_data_o);
    end
    dataZ_clr_i = 1; dataZ_en_i = 1;
    tick();
    checks++;
    if (memZ_data_o !== '0) begin
      errors++;
      $display("FAIL acc_clr_priority: got %0d expected 0", memZ_data_o);
    end
  endtask

  task automatic test_index_load();
    apply_reset();
    busy_i = 0; start_i = 1; sizeX_i = 10; sizeY_i = 2; i_clr_i = 1;
    tick();
    busy_i = 1;
    for (int r = 0; r < 4; r++) begin
      i_en_i = 1;
      tick();
    end
    j_en_i = 1; selJ_i = 1;
    tick();
    memX_addr_en_i = 1; memY_addr_en_i = 1; selY_i = 0;
    tick();
    checks++;
    if (memX_addr_o !== AW'(3) || memY_addr_o !== AW'(1)) begin
      errors++;
      $display("FAIL j_load: got x=%0d y=%0d expected x=3 y=1", memX_addr_o, memY_addr_o);
    end
    k_en_i = 1; selK_i = 0;
    tick();
    memY_addr_en_i = 1; selY_i = 1; k_en_i = 1; selK_i = 1;
    tick();
    checks++;
    if (memY_addr_o !== AW'(1)) begin
      errors++;
      $display("FAIL k_load: got %0d expected 1", memY_addr_o);
    end
    memY_addr_en_i = 1; selY_i = 1;
    tick();
    checks++;
    if (memY_addr_o !== AW'(0)) begin
      errors++;
      $display("FAIL k_dec: got %0d expected 0", memY_addr_o);
    end
    i_en_i = 1; selI_i = 1;
    tick();
    checks++;
    if (comp_i_sizeY_o !== 1'b0 || comp_i_sizeX_o !== 1'b1 || comp_j_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL i_load_sy: got iY=%0b iX=%0b jv=%0b expected 0 1 0",
               comp_i_sizeY_o, comp_i_sizeX_o, comp_j_valid_o);
    end
    busy_i = 0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    memX[0] = 2; memY[0] = 11;
    tick();
    tick();
    dataZ_en_i = 1;
    tick();
    j_en_i = 1; memZ_addr_en_i = 1;
    tick();
    memX_addr_en_i = 1; memZ_addr_en_i = 1;
    tick();
    writeZ_i = 1;
    #1;
    checks++;
    if (memZ_data_o !== ACCW'(22) || memZ_addr_o !== (AW+1)'(2) || memX_addr_o !== AW'(1) || memZ_we_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got acc=%0d z=%0d x=%0d we=%0b expected 22 2 1 1",
               memZ_data_o, memZ_addr_o, memX_addr_o, memZ_we_o);
    end
    rstn = 0;
    #1;
    checks++;
    if (memZ_data_o !== '0 || memZ_addr_o !== '0 || memX_addr_o !== '0 || memZ_we_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got acc=%0d z=%0d x=%0d we=%0b expected 0 0 0 0",
               memZ_data_o, memZ_addr_o, memX_addr_o, memZ_we_o);
    end
    @(posedge clk);
    #1;
    clear_ctrl();
    rstn = 1;
  endtask

  initial begin
    test_reset();
    test_conv_3x2();
    test_conv_1x1();
    test_size_load();
    test_acc_priority();
    test_index_load();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
